// File: rtl/tcdm64_sram_slave.sv
// 64-bit TCDM SRAM slave: single outstanding request, fixed LATENCY response.
// Define TCDM64_SLV_ADDR_ERR_EN to flag out-of-range accesses instead of wrapping.

module tcdm64_sram_lane #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

module tcdm64_sram_slave #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] add_i,
    input  logic        wen_i,
    input  logic [63:0] wdata_i,
    input  logic [7:0]  be_i,
    output logic        gnt_o,
    output logic        r_valid_o,
    output logic [63:0] r_rdata_o,
    output logic        r_opc_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic          wen;
        logic [63:0]   wdata;
        logic [7:0]    be;
        logic          err;
    } req_t;

    state_t          state;
    logic [2:0]      cnt;
    req_t            nreq;
    req_t            cap;
    logic            wr_pend;
    logic            r_valid;
    logic [7:0][7:0] rd_word;

    always_comb begin
        nreq.idx   = AW'((add_i - BASE_ADDR) >> 3);
        nreq.wen   = wen_i;
        nreq.wdata = wdata_i;
        nreq.be    = be_i;
`ifdef TCDM64_SLV_ADDR_ERR_EN
        // 33-bit compare so BASE_ADDR + 8*DEPTH cannot overflow
        nreq.err   = ({1'b0, add_i} < {1'b0, BASE_ADDR}) ||
                     ({1'b0, add_i} >= ({1'b0, BASE_ADDR} + 33'(8 * DEPTH)));
`else
        nreq.err   = 1'b0;
`endif
    end

    // cnt holds response cycles remaining after the current one
    assign r_valid = !rst_i && (state == S_WAIT) && (cnt == 3'd0);
    assign gnt_o   = req_i && !rst_i && ((state == S_IDLE) || r_valid);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            wr_pend <= 1'b0;
        end else begin
            wr_pend <= gnt_o && !nreq.wen && !nreq.err;
            if (gnt_o) begin
                state <= S_WAIT;
                cnt   <= 3'(LATENCY - 1);
            end else if (r_valid) begin
                state <= S_IDLE;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt_o) cap <= nreq;
    end

    // Write lands one cycle after grant; reads see it through the async array read
    for (genvar b = 0; b < 8; b++) begin : g_lane
        tcdm64_sram_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
            .clk   (clk_i),
            .we    (wr_pend && cap.be[b]),
            .addr  (cap.idx),
            .wdata (cap.wdata[8*b +: 8]),
            .rdata (rd_word[b])
        );
    end

    assign r_valid_o = r_valid;
    assign r_rdata_o = (r_valid && cap.wen && !cap.err) ? rd_word : 64'd0;
`ifdef TCDM64_SLV_ADDR_ERR_EN
    assign r_opc_o   = r_valid && cap.err;
`else
    assign r_opc_o   = 1'b0;
`endif
endmodule

// File: tb/tb_tcdm64_sram_slave.sv
// Directed bench for tcdm64_sram_slave: LATENCY=1 and LATENCY=3 instances side by side.

module tb_tcdm64_sram_slave;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic        a_rst, a_req, a_wen, a_gnt, a_rvalid, a_opc;
    logic [31:0] a_add;
    logic [63:0] a_wdata, a_rdata;
    logic [7:0]  a_be;
    logic        b_rst, b_req, b_wen, b_gnt, b_rvalid, b_opc;
    logic [31:0] b_add;
    logic [63:0] b_wdata, b_rdata;
    logic [7:0]  b_be;

    tcdm64_sram_slave #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(32'h1000_0000)) u_l1 (
        .clk_i(clk), .rst_i(a_rst), .req_i(a_req), .add_i(a_add), .wen_i(a_wen),
        .wdata_i(a_wdata), .be_i(a_be), .gnt_o(a_gnt), .r_valid_o(a_rvalid),
        .r_rdata_o(a_rdata), .r_opc_o(a_opc)
    );

    tcdm64_sram_slave #(.DEPTH(1024), .LATENCY(3), .BASE_ADDR(32'h1000_0000)) u_l3 (
        .clk_i(clk), .rst_i(b_rst), .req_i(b_req), .add_i(b_add), .wen_i(b_wen),
        .wdata_i(b_wdata), .be_i(b_be), .gnt_o(b_gnt), .r_valid_o(b_rvalid),
        .r_rdata_o(b_rdata), .r_opc_o(b_opc)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle: drive mid-cycle at negedge, outputs settle for sampling at +1
    task automatic drv_a(input bit rst, input bit req, input bit wen, input logic [31:0] add,
                         input logic [63:0] wd, input logic [7:0] be);
        @(negedge clk);
        a_rst = rst; a_req = req; a_wen = wen; a_add = add; a_wdata = wd; a_be = be;
        #1;
    endtask

    task automatic drv_b(input bit rst, input bit req, input bit wen, input logic [31:0] add,
                         input logic [63:0] wd, input logic [7:0] be);
        @(negedge clk);
        b_rst = rst; b_req = req; b_wen = wen; b_add = add; b_wdata = wd; b_be = be;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1; a_req = 0; a_wen = 1; a_add = '0; a_wdata = '0; a_be = '0;
        b_rst = 1; b_req = 0; b_wen = 1; b_add = '0; b_wdata = '0; b_be = '0;

        // ---------------- LATENCY=1 ----------------
        drv_a(1, 1, 0, 32'h1000_0008, 64'h0BAD, 8'hFF);
        chk("rst_gnt",    64'(a_gnt),    0);
        chk("rst_rvalid", 64'(a_rvalid), 0);
        chk("rst_rdata",  a_rdata,       0);
        chk("rst_opc",    64'(a_opc),    0);
        drv_a(1, 0, 1, 32'h0, 64'h0, 8'h00);

        drv_a(0, 1, 0, 32'h1000_0008, 64'h1122334455667788, 8'hFF);
        chk("wr_gnt",    64'(a_gnt),    1);
        chk("wr_rvalid", 64'(a_rvalid), 0);
        drv_a(0, 1, 1, 32'h1000_0008, 64'h0, 8'h00);
        chk("rd_gnt",      64'(a_gnt),    1);
        chk("wr_rsp",      64'(a_rvalid), 1);
        chk("wr_rsp_data", a_rdata,       0);
        drv_a(0, 0, 1, 32'h0, 64'h0, 8'h00);
        chk("idle_gnt",  64'(a_gnt),    0);
        chk("rd_rsp",    64'(a_rvalid), 1);
        chk("rd_data",   a_rdata,       64'h1122334455667788);
        chk("rd_opc",    64'(a_opc),    0);
        drv_a(0, 0, 1, 32'h0, 64'h0, 8'h00);
        chk("quiet_rvalid", 64'(a_rvalid), 0);
        chk("quiet_rdata",  a_rdata,       0);

        // partial write, then be=0 write that must leave the word alone
        drv_a(0, 1, 0, 32'h1000_0010, 64'h0, 8'hFF);
        drv_a(0, 1, 0, 32'h1000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        drv_a(0, 1, 0, 32'h1000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00);
        chk("be0_gnt", 64'(a_gnt), 1);
        drv_a(0, 1, 1, 32'h1000_0010, 64'h0, 8'h00);
        chk("be0_rsp", 64'(a_rvalid), 1);
        drv_a(0, 0, 1, 32'h0, 64'h0, 8'h00);
        chk("partial_data", a_rdata, 64'h0000_0000_FFFF_FFFF);

        // address range: word 0, out-of-range write, then reads
        drv_a(0, 1, 0, 32'h1000_0000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
        drv_a(0, 1, 0, 32'h1000_2000, 64'h5555_5555_5555_5555, 8'hFF);
        drv_a(0, 1, 1, 32'h1000_2000, 64'h0, 8'h00);
`ifdef TCDM64_SLV_ADDR_ERR_EN
        chk("oob_wr_opc", 64'(a_opc), 1);
`else
        chk("oob_wr_opc", 64'(a_opc), 0);
`endif
        drv_a(0, 1, 1, 32'h1000_0005, 64'h0, 8'h00);
        chk("oob_rd_rvalid", 64'(a_rvalid), 1);
`ifdef TCDM64_SLV_ADDR_ERR_EN
        chk("oob_rd_opc",  64'(a_opc), 1);
        chk("oob_rd_data", a_rdata,    0);
`else
        chk("oob_rd_opc",  64'(a_opc), 0);
        chk("oob_rd_data", a_rdata,    64'h5555_5555_5555_5555);
`endif
        drv_a(0, 0, 1, 32'h0, 64'h0, 8'h00);
        chk("w0_opc", 64'(a_opc), 0);
`ifdef TCDM64_SLV_ADDR_ERR_EN
        chk("w0_data", a_rdata, 64'hDEAD_BEEF_CAFE_F00D);
`else
        chk("w0_data", a_rdata, 64'h5555_5555_5555_5555);
`endif

        // ---------------- LATENCY=3 ----------------
        drv_b(1, 1, 0, 32'h1000_0008, 64'h0BAD, 8'hFF);
        chk("l3_rst_gnt", 64'(b_gnt), 0);
        for (int c = 0; c <= 6; c++) begin
            drv_b(0, c < 6, 0, 32'h1000_0008, 64'h0102_0304_0506_0708, 8'hFF);
            chk($sformatf("l3_gnt_c%0d", c),    64'(b_gnt),    64'((c == 0) || (c == 3)));
            chk($sformatf("l3_rvalid_c%0d", c), 64'(b_rvalid), 64'((c == 3) || (c == 6)));
        end

        drv_b(0, 1, 1, 32'h1000_0008, 64'h0, 8'h00);
        chk("l3_rd_gnt", 64'(b_gnt), 1);
        drv_b(0, 0, 1, 32'h0, 64'h0, 8'h00);
        drv_b(0, 0, 1, 32'h0, 64'h0, 8'h00);
        chk("l3_rd_early", 64'(b_rvalid), 0);
        drv_b(0, 0, 1, 32'h0, 64'h0, 8'h00);
        chk("l3_rd_rvalid", 64'(b_rvalid), 1);
        chk("l3_rd_data",   b_rdata,       64'h0102_0304_0506_0708);

        // reset one cycle after a grant; a write offered during reset must not land
        drv_b(0, 1, 1, 32'h1000_0008, 64'h0, 8'h00);
        chk("l3_pre_rst_gnt", 64'(b_gnt), 1);
        drv_b(1, 1, 0, 32'h1000_0008, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF);
        chk("l3_rst_mid_gnt",    64'(b_gnt),    0);
        chk("l3_rst_mid_rvalid", 64'(b_rvalid), 0);
        for (int c = 2; c <= 10; c++) begin
            drv_b(0, 0, 1, 32'h0, 64'h0, 8'h00);
            chk($sformatf("l3_discard_c%0d", c), 64'(b_rvalid), 0);
        end
        drv_b(0, 1, 1, 32'h1000_0008, 64'h0, 8'h00);
        chk("l3_post_gnt", 64'(b_gnt), 1);
        drv_b(0, 0, 1, 32'h0, 64'h0, 8'h00);
        drv_b(0, 0, 1, 32'h0, 64'h0, 8'h00);
        drv_b(0, 0, 1, 32'h0, 64'h0, 8'h00);
        chk("l3_post_rvalid", 64'(b_rvalid), 1);
        chk("l3_post_data",   b_rdata,       64'h0102_0304_0506_0708);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
